ushift_reg: RTL and testbench
=============================

# ushift_reg

Parametrised multi-mode register, the successor to the plain parallel-in/parallel-out register in the datapath. It supports hold, parallel load, logical shift left and right with serial fill, rotate, clear, and a self-timed burst mode. In burst mode it loads a word and serialises it LSB-first over N enabled cycles, with busy and done status. It sits between the datapath register file and the serial I/O ports.

## Interface
Parameters:
- N, 16, register width in bits; N >= 2.
- CW, $clog2(N), burst counter width (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, clock enable; 0 freezes q, state and counter.
- mode, input, 3, operation select (see Operation).
- d, input, N, parallel load data.
- sin_l, input, 1, serial fill into the MSB on right shifts and burst shifts.
- sin_r, input, 1, serial fill into the LSB on left shifts.
- q, output, N, register contents.
- sout, output, 1, serial out, combinational q[0].
- busy, output, 1, high while state is BURST.
- done, output, 1, high for exactly one cycle in state DONE.

## Operation
- Reset (rst=1 at an edge) takes priority over en and mode: q=0, state=IDLE, cnt=0, so busy=0, done=0, sout=0.
- In IDLE or DONE with en=1, mode decodes as follows:
  - 000: hold.
  - 001: q<=d.
  - 010: q<={q[N-2:0],sin_r}.
  - 011: q<={sin_l,q[N-1:1]}.
  - 100: rotate left, q<={q[N-2:0],q[N-1]}.
  - 101: rotate right, q<={q[0],q[N-1:1]}.
  - 110: q<=0.
  - 111: burst start, q<=d, cnt<=0, state<=BURST.
- In IDLE or DONE with en=0: q and state hold. DONE still exits as described under DONE.
- BURST:
  - mode is ignored.
  - Each edge with en=1: q<={sin_l,q[N-1:1]}.
  - If cnt==N-1, state<=DONE; otherwise cnt<=cnt+1.
  - en=0 stalls shift and counter. busy stays high.
- DONE:
  - done=1.
  - At the next edge, state<=IDLE regardless of en, unless en=1 and mode=111, which starts a new burst (state<=BURST).
  - Other modes in DONE with en=1 act as in IDLE and go to IDLE.
- Burst word order: during the k-th enabled BURST cycle (k=0..N-1), sout=d[k]. After the burst, q holds the N sin_l bits shifted in.
- States: IDLE(00), BURST(01), DONE(10). Encoding 11 is illegal and must recover to IDLE at the next edge with q held.

## Timing
- Every mode takes effect at the first rising edge with en=1; q is visible one cycle later. No combinational path from d or mode to q.
- sout is combinational from q only.
- Burst latency:
  - Start edge E0 leads to busy=1, sout=d[0] in the following cycle.
  - With en held high, busy lasts exactly N cycles.
  - done=1 in cycle N+1 after E0.
  - busy=0 and done=1 are never simultaneous.
- Stalls extend busy by one cycle per en=0 cycle. sout is stable during a stall.
- rst mid-burst aborts the burst at that edge: no done pulse, q=0.
- Back-to-back burst: mode=111 with en=1 in the DONE cycle gives busy=1 in the next cycle with no IDLE gap.
- Wrap: cnt never exceeds N-1. This holds when N is a power of two, where cnt must not wrap.

## Test plan
- Reset values, N=16: drive rst=1 with d=FFFF, mode=001, en=1 -> q=0000, busy=0, done=0, sout=0. Release rst, load A5C3 -> q=A5C3 next cycle.
- Shift and rotate from q=8001:
  - 010 with sin_r=1 -> 0003.
  - 011 with sin_l=0 from 8001 -> 4000.
  - 100 from 8001 -> 0003.
  - 101 from 8001 -> C000.
  - en=0 with any mode -> q unchanged.
- Burst, d=B00F, sin_l=1, en=1 continuous:
  - sout sequence 1,1,1,1,0,0,0,0,0,0,0,0,1,1,0,1 over 16 busy cycles.
  - done pulse for one cycle, then q=FFFF and busy=0.
- Burst with stalls: en=0 for 3 cycles at k=5 -> busy lasts 19 cycles, sout holds d[5] during the stall, done occurs once.
- rst at k=7 mid-burst -> next cycle busy=0, done=0, q=0000, state IDLE. A following mode=111 restarts the burst cleanly.
- Back-to-back: in the DONE cycle apply mode=111, d=0001 -> done=1 that cycle, busy=1 and sout=1 in the next cycle, no idle gap.

Source files
------------

// File: rtl/ushift_reg_if.sv
// Control/data bundle for ushift_reg: the datapath side drives mode, data and serial fills,
// and the register returns its contents and burst status.
interface ushift_reg_if #(
    parameter int N = 16
);
    logic         en;
    logic [2:0]   mode;
    logic [N-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic [N-1:0] q;
    logic         sout;
    logic         busy;
    logic         done;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, sout, busy, done
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, sout, busy, done
    );
endinterface

// File: rtl/ushift_reg.sv
// Multi-mode N-bit register: hold/load/shift/rotate/clear, plus a self-timed burst that
// serialises a loaded word LSB-first on sout over N enabled cycles.
module ushift_reg #(
    parameter int N  = 16,
    parameter int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    ushift_reg_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_CLR   = 3'b110,
        MODE_BURST = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state, state_nx;
    logic [N-1:0]  q_r, q_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            q_r   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            q_r   <= q_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nx = state;
        q_nx     = q_r;
        cnt_nx   = cnt;

        case (state)
            IDLE, DONE: begin
                // DONE lasts one cycle whatever en does; a new burst overrides this below.
                if (state == DONE) state_nx = IDLE;
                if (bus.en) begin
                    case (mode_e'(bus.mode))
                        MODE_HOLD:  q_nx = q_r;
                        MODE_LOAD:  q_nx = bus.d;
                        MODE_SHL:   q_nx = {q_r[N-2:0], bus.sin_r};
                        MODE_SHR:   q_nx = {bus.sin_l, q_r[N-1:1]};
                        MODE_ROL:   q_nx = {q_r[N-2:0], q_r[N-1]};
                        MODE_ROR:   q_nx = {q_r[0], q_r[N-1:1]};
                        MODE_CLR:   q_nx = '0;
                        MODE_BURST: begin
                            q_nx     = bus.d;
                            cnt_nx   = '0;
                            state_nx = BURST;
                        end
                    endcase
                end
            end

            BURST: begin
                if (bus.en) begin
                    q_nx = {bus.sin_l, q_r[N-1:1]};
                    if (cnt == CNT_LAST) state_nx = DONE;
                    else                 cnt_nx   = cnt + 1'b1;
                end
            end

            // Illegal encoding recovers to IDLE with q held.
            default: state_nx = IDLE;
        endcase
    end

    assign bus.q    = q_r;
    assign bus.sout = q_r[0];
    assign bus.busy = (state == BURST);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_ushift_reg.sv
// Self-checking bench for ushift_reg: directed scenarios, then randomized traffic,
// all compared against a behavioural model of the register kept here.
module tb_ushift_reg;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;

    ushift_reg_if #(.N(N)) bus ();

    ushift_reg #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0=idle, 1=burst, 2=done; left = enabled burst cycles remaining.
    logic [N-1:0] m_q;
    int           m_phase;
    int           m_left;
    logic         exp_bits[$];
    int           busy_cnt;
    int           done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_q     = '0;
            m_phase = 0;
            exp_bits.delete();
        end else if (m_phase == 1) begin
            if (bus.en) begin
                m_q = (m_q >> 1) | (N'(bus.sin_l) << (N - 1));
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            m_phase = 0;
            if (bus.en) begin
                case (bus.mode)
                    3'd1: m_q = bus.d;
                    3'd2: m_q = (m_q << 1) | N'(bus.sin_r);
                    3'd3: m_q = (m_q >> 1) | (N'(bus.sin_l) << (N - 1));
                    3'd4: m_q = (m_q << 1) | (m_q >> (N - 1));
                    3'd5: m_q = (m_q >> 1) | (m_q << (N - 1));
                    3'd6: m_q = '0;
                    3'd7: begin
                        m_q     = bus.d;
                        m_phase = 1;
                        m_left  = N;
                        exp_bits.delete();
                        for (int i = 0; i < N; i++) exp_bits.push_back(bus.d[i]);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Inputs are already set; check burst word order before the edge, then compare after it.
    task automatic tick();
        if (!rst && m_phase == 1 && bus.en && exp_bits.size() > 0) begin
            check("burst_sout", 32'(bus.sout), 32'(exp_bits[0]));
            void'(exp_bits.pop_front());
        end
        model_step();
        @(posedge clk);
        #1;
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        check("q",    32'(bus.q),    32'(m_q));
        check("busy", 32'(bus.busy), 32'(m_phase == 1));
        check("done", 32'(bus.done), 32'(m_phase == 2));
        check("sout", 32'(bus.sout), 32'(m_q[0]));
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [N-1:0] dv,
                         input logic sl, input logic sr);
        bus.en    = e;
        bus.mode  = m;
        bus.d     = dv;
        bus.sin_l = sl;
        bus.sin_r = sr;
    endtask

    task automatic load(input logic [N-1:0] v);
        drive(1'b1, 3'd1, v, 1'b0, 1'b0);
        tick();
    endtask

    logic [N-1:0] ser;

    initial begin
        m_q = '0; m_phase = 0; m_left = 0; busy_cnt = 0; done_cnt = 0;

        // Reset dominates en/mode.
        rst = 1'b1;
        drive(1'b1, 3'd1, 16'hFFFF, 1'b0, 1'b0);
        tick();
        check("rst_q",    32'(bus.q), 32'h0000);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sout", 32'(bus.sout), 32'd0);
        rst = 1'b0;
        load(16'hA5C3);
        check("load", 32'(bus.q), 32'hA5C3);

        // Shifts and rotates from 8001.
        load(16'h8001); drive(1'b1, 3'd2, '0, 1'b0, 1'b1); tick(); check("shl",  32'(bus.q), 32'h0003);
        load(16'h8001); drive(1'b1, 3'd3, '0, 1'b0, 1'b1); tick(); check("shr",  32'(bus.q), 32'h4000);
        load(16'h8001); drive(1'b1, 3'd4, '0, 1'b1, 1'b0); tick(); check("rol",  32'(bus.q), 32'h0003);
        load(16'h8001); drive(1'b1, 3'd5, '0, 1'b1, 1'b0); tick(); check("ror",  32'(bus.q), 32'hC000);
        load(16'h8001);
        for (int m = 0; m < 8; m++) begin
            drive(1'b0, 3'(m), 16'h1234, 1'b1, 1'b1);
            tick();
            check("en0_hold", 32'(bus.q), 32'h8001);
        end
        drive(1'b1, 3'd6, 16'h1234, 1'b1, 1'b1); tick(); check("clr", 32'(bus.q), 32'h0000);

        // Continuous burst of B00F with sin_l=1; mode is ignored while busy.
        drive(1'b1, 3'd7, 16'hB00F, 1'b1, 1'b0);
        tick();
        check("burst_start_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < N; k++) begin
            ser[k] = bus.sout;
            drive(1'b1, 3'($urandom_range(0, 6)), 16'($urandom), 1'b1, 1'b0);
            tick();
        end
        check("burst_serial", 32'(ser), 32'hB00F);
        check("burst_done",   32'(bus.done), 32'd1);
        drive(1'b1, 3'd0, '0, 1'b0, 1'b0);
        tick();
        check("burst_q",     32'(bus.q), 32'hFFFF);
        check("burst_idle",  32'(bus.busy), 32'd0);

        // Burst with a 3-cycle stall at k=5.
        busy_cnt = 0; done_cnt = 0;
        drive(1'b1, 3'd7, 16'h6C39, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < N; k++) begin
            if (k == 5) begin
                for (int s = 0; s < 3; s++) begin
                    drive(1'b0, 3'd0, '0, 1'b1, 1'b1);
                    tick();
                    check("stall_sout", 32'(bus.sout), 32'(1'b1)); // d[5] of 6C39
                end
            end
            drive(1'b1, 3'd0, '0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 3'd0, '0, 1'b0, 1'b0);
        tick();
        check("stall_busy_len", 32'(busy_cnt), 32'd19);
        check("stall_done_cnt", 32'(done_cnt), 32'd1);

        // Reset at k=7 aborts the burst; a new burst then runs cleanly.
        drive(1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q",    32'(bus.q), 32'h0000);
        drive(1'b1, 3'd7, 16'h1234, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < N; k++) tick();
        check("restart_done", 32'(bus.done), 32'd1);

        // Back-to-back burst from the DONE cycle.
        drive(1'b1, 3'd7, 16'h0001, 1'b0, 1'b0);
        check("b2b_done", 32'(bus.done), 32'd1);
        tick();
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_sout", 32'(bus.sout), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 4) != 0), 3'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
